// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode constants, FSM encoding and default width for ula and ula_ctrl
package ula_pkg;
  localparam int ULA_WIDTH = 8;
  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SLT = 3'b101;
  localparam logic [2:0] ULA_EQ  = 3'b110;
  localparam logic [2:0] ULA_NE  = 3'b111;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/ula_ctrl_if.sv
// ula_ctrl_if: command and result valid/ready channels between a command source and ula_ctrl
interface ula_ctrl_if #(
  parameter int WIDTH = ula_pkg::ULA_WIDTH
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_op;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [2:0]       res_op;
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    input  cmd_ready, res_valid, res_data, res_op
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    output cmd_ready, res_valid, res_data, res_op
  );
endinterface

// File: rtl/ula.sv
// ula: 8-bit ALU with one registered output stage, the target driven by ula_ctrl
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] s_o
);
  logic [WIDTH-1:0] r;
  always_comb begin
    r = opcode_i == ULA_ADD ? a_i + b_i :
        opcode_i == ULA_SUB ? a_i - b_i :
        opcode_i == ULA_AND ? a_i & b_i :
        opcode_i == ULA_OR  ? a_i | b_i :
        opcode_i == ULA_XOR ? a_i ^ b_i :
        opcode_i == ULA_SLT ? {{(WIDTH-1){1'b0}}, a_i < b_i} :
        opcode_i == ULA_EQ  ? {{(WIDTH-1){1'b0}}, a_i == b_i} :
                              {{(WIDTH-1){1'b0}}, a_i != b_i};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_o <= '0;
    else     s_o <= r;
  end
endmodule

// File: rtl/ula_ctrl.sv
// ula_ctrl: one-at-a-time handshaked initiator for ula; latches operands, waits LAT edges,
// captures the result and returns it on the result channel.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  ula_ctrl_if.slave        bus,
  output logic [WIDTH-1:0] ula_a_o,
  output logic [WIDTH-1:0] ula_b_o,
  output logic [2:0]       ula_opcode_o,
  input  logic [WIDTH-1:0] ula_s_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o
);
  localparam logic [3:0] LAT_C = 4'(LAT);
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
  // ready/valid come from state alone, so the ports never combine inputs into outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        state_d = S_WAIT;
        cnt_d   = LAT_C;
        a_d     = bus.cmd_a;
        b_d     = bus.cmd_b;
        op_d    = bus.cmd_op;
      end
      S_WAIT: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        data_d  = ula_s_i;
        state_d = S_DONE;
      end
      S_DONE: if (bus.res_ready) begin
        state_d = S_IDLE;
        count_d = count_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.res_valid = state_q == S_DONE;
  assign bus.res_data  = data_q;
  assign bus.res_op    = op_q;
  assign busy_o        = state_q != S_IDLE;
  assign ula_a_o       = a_q;
  assign ula_b_o       = b_q;
  assign ula_opcode_o  = op_q;
  assign op_count_o    = count_q;
endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: directed vector bench for ula_ctrl driving a ula, with LAT=1 and LAT=4/CNT_W=2 instances
module tb_ula_ctrl;
  import ula_pkg::*;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;
  ula_ctrl_if #(.WIDTH(8)) b0 ();
  ula_ctrl_if #(.WIDTH(8)) b1 ();
  logic [7:0]  ua0, ub0, us0, ua1, ub1, us1;
  logic [2:0]  uo0, uo1;
  logic        busy0, busy1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  ula_ctrl #(.WIDTH(8), .LAT(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst0), .bus(b0), .ula_a_o(ua0), .ula_b_o(ub0),
    .ula_opcode_o(uo0), .ula_s_i(us0), .busy_o(busy0), .op_count_o(cnt0)
  );
  ula #(.WIDTH(8)) alu0 (.clk(clk), .rst(rst0), .a_i(ua0), .b_i(ub0), .opcode_i(uo0), .s_o(us0));
  ula_ctrl #(.WIDTH(8), .LAT(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1), .ula_a_o(ua1), .ula_b_o(ub1),
    .ula_opcode_o(uo1), .ula_s_i(us1), .busy_o(busy1), .op_count_o(cnt1)
  );
  ula #(.WIDTH(8)) alu1 (.clk(clk), .rst(rst1), .a_i(ua1), .b_i(ub1), .opcode_i(uo1), .s_o(us1));

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic        busy;
    logic [7:0]  data;
    logic [7:0]  ua;
    logic [2:0]  op;
    logic [15:0] cnt;
  } obs_t;
  obs_t o0, o1;
  assign o0 = '{b0.cmd_ready, b0.res_valid, busy0, b0.res_data, ua0, b0.res_op, cnt0};
  assign o1 = '{b1.cmd_ready, b1.res_valid, busy1, b1.res_data, ua1, b1.res_op, {14'd0, cnt1}};

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[7];

  int checks = 0;
  int errors = 0;

  function automatic obs_t ob(input int s);
    return s != 0 ? o1 : o0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input int a, input int b, input logic [2:0] op, input logic rr);
    if (s == 0) begin
      b0.cmd_valid = v; b0.cmd_a = 8'(a); b0.cmd_b = 8'(b); b0.cmd_op = op; b0.res_ready = rr;
    end else begin
      b1.cmd_valid = v; b1.cmd_a = 8'(a); b1.cmd_b = 8'(b); b1.cmd_op = op; b1.res_ready = rr;
    end
  endtask

  // full transaction with res_ready held high; lat counts edges from accept to res_valid
  task automatic do_op(input int s, input int a, input int b, input logic [2:0] op,
                       input int exp, input int exp_cnt, input int exp_lat, input string tag);
    int lat;
    logic got;
    @(negedge clk);
    chk({tag, " ready_before"}, ob(s).rdy, 1);
    drive(s, 1'b1, a, b, op, 1'b1);
    @(posedge clk);
    #1 drive(s, 1'b0, 0, 0, 3'd0, 1'b1);
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = ob(s).vld;
    end
    chk({tag, " latency"}, got ? lat : -1, exp_lat);
    chk({tag, " res_data"}, ob(s).data, exp);
    chk({tag, " res_op"}, ob(s).op, op);
    @(negedge clk);
    chk({tag, " op_count"}, ob(s).cnt, exp_cnt);
    chk({tag, " ready_after"}, ob(s).rdy, 1);
    chk({tag, " ula_a_held"}, ob(s).ua, a & 8'hff);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    tbl[0] = '{8'd5,  8'd10, ULA_ADD, 8'd15};
    tbl[1] = '{8'd5,  8'd10, ULA_SUB, 8'd251};
    tbl[2] = '{8'd10, 8'd5,  ULA_SUB, 8'd5};
    tbl[3] = '{8'd8,  8'd8,  ULA_EQ,  8'd1};
    tbl[4] = '{8'd5,  8'd10, ULA_EQ,  8'd0};
    tbl[5] = '{8'd8,  8'd8,  ULA_NE,  8'd0};
    tbl[6] = '{8'd5,  8'd10, ULA_NE,  8'd1};
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 0, 0, 3'd0, 1'b0);
    drive(1, 1'b0, 0, 0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset%0d cmd_ready", s), ob(s).rdy, 1);
      chk($sformatf("reset%0d res_valid", s), ob(s).vld, 0);
      chk($sformatf("reset%0d busy", s), ob(s).busy, 0);
      chk($sformatf("reset%0d ula_a", s), ob(s).ua, 0);
      chk($sformatf("reset%0d res_data", s), ob(s).data, 0);
      chk($sformatf("reset%0d op_count", s), ob(s).cnt, 0);
    end
    chk("reset ula_b", ub0, 0);
    chk("reset ula_opcode", uo0, 0);

    for (int i = 0; i < 7; i++)
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, i + 1, 2, $sformatf("vec%0d", i));

    // result backpressure while a new command is offered with changing operands
    @(negedge clk);
    drive(0, 1'b1, 20, 3, ULA_ADD, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 0, 0, ULA_ADD, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o0.vld && n < 20);
    chk("bp res_valid", o0.vld, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, i * 37 + 1, i * 11 + 2, ULA_SUB, 1'b0);
      @(negedge clk);
      chk($sformatf("bp%0d res_data", i), o0.data, 23);
      chk($sformatf("bp%0d cmd_ready", i), o0.rdy, 0);
      chk($sformatf("bp%0d ula_a", i), o0.ua, 20);
      chk($sformatf("bp%0d res_valid", i), o0.vld, 1);
    end
    drive(0, 1'b1, 1, 2, ULA_ADD, 1'b1);
    @(negedge clk);
    chk("bp handshake cmd_ready", o0.rdy, 1);
    chk("bp handshake op_count", o0.cnt, 8);
    chk("bp handshake ula_a", o0.ua, 20);
    chk("bp handshake busy", o0.busy, 0);
    @(negedge clk);
    chk("bp second accept ula_a", o0.ua, 1);
    chk("bp second accept busy", o0.busy, 1);
    drive(0, 1'b0, 0, 0, ULA_ADD, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o0.vld && n < 20);
    chk("bp second res_valid", o0.vld, 1);
    chk("bp second res_data", o0.data, 3);
    @(negedge clk);
    chk("bp second op_count", o0.cnt, 9);

    // LAT=4 instance: one op, then reset two cycles into WAIT
    do_op(1, 1, 1, ULA_ADD, 2, 1, 5, "lat4 pre");
    @(negedge clk);
    drive(1, 1'b1, 9, 9, ULA_ADD, 1'b1);
    @(posedge clk);
    #1 drive(1, 1'b0, 0, 0, ULA_ADD, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid busy before rst", o1.busy, 1);
    rst1 = 1'b1;
    #1;
    chk("rst busy", o1.busy, 0);
    chk("rst ula_a", o1.ua, 0);
    chk("rst res_data", o1.data, 0);
    chk("rst op_count", o1.cnt, 0);
    chk("rst res_valid", o1.vld, 0);
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    #1 chk("rst release cmd_ready", o1.rdy, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o1.vld) seen++;
    end
    chk("rst no result", seen, 0);
    do_op(1, 3, 4, ULA_ADD, 7, 1, 5, "wrap1");
    do_op(1, 100, 200, ULA_ADD, 44, 2, 5, "wrap2");
    do_op(1, 0, 1, ULA_SUB, 255, 3, 5, "wrap3");
    do_op(1, 7, 7, ULA_EQ, 1, 0, 5, "wrap0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
